calc_alu: RTL and testbench

CALC_ALU -- requirements
Module: calc_alu

---
 rtl/calc_pkg.sv | 22 ++
 rtl/div_restoring.sv | 69 ++++++
 rtl/calc_alu.sv | 156 +++++++++++++++
 tb/tb_calc_alu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator ALU slice.
// Provides the default operand width, the display saturation limit,
// the operation encoding and the controller state encoding.
package calc_pkg;

    localparam int unsigned WIDTH     = 14;
    localparam int unsigned MAX_VALUE = 9999;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2,
        OpDiv = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/div_restoring.sv
// Iterative restoring divider, one quotient bit per cycle, quotient only.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   start             load dividend/divisor; the first iteration runs on this edge
//   dividend, divisor unsigned operands (divisor must be non-zero)
//   busy              high while the remaining WIDTH-1 iterations run
//   quotient          valid once busy has dropped
module div_restoring #(
    parameter int unsigned WIDTH = calc_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;

    logic [WIDTH-1:0] rem_in, quo_in, dvs_in, rem_next, quo_next;
    logic [WIDTH:0]   shifted, diff;
    logic             borrow;

    // Doing the first step straight from the inputs lets the quotient be ready
    // one cycle earlier, so the controller can latch it on its final CALC edge.
    always_comb begin
        rem_in   = start ? '0 : rem_q;
        quo_in   = start ? dividend : quo_q;
        dvs_in   = start ? divisor : dvs_q;
        shifted  = {rem_in, quo_in[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_in};
        borrow   = diff[WIDTH];
        rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quo_in[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= rem_next;
            quo_q  <= quo_next;
            dvs_q  <= divisor;
            cnt_q  <= CntW'(1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign quotient = quo_q;

endmodule

// File: rtl/calc_alu.sv
// Four-function calculator ALU feeding a 4-digit display.
// Ports:
//   clk, reset           clock and asynchronous active-low reset
//   start                request pulse, only sampled while idle
//   op                   0 ADD, 1 SUB, 2 MUL, 3 DIV
//   operand_a, operand_b unsigned operands, clamped to MAX_VALUE on capture
//   result               last completed result, saturated to 0..MAX_VALUE
//   busy                 high while calculating
//   done                 one-cycle pulse when result/error update
//   error                overflow, underflow or divide-by-zero of the last operation
module calc_alu #(
    parameter int unsigned WIDTH     = calc_pkg::WIDTH,
    parameter int unsigned MAX_VALUE = calc_pkg::MAX_VALUE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error
);

    import calc_pkg::*;

    localparam int unsigned      CntW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);

    state_t             state_q;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q, b_q, mplier_q, result_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [CntW-1:0]    cnt_q;
    logic               error_q;

    logic [WIDTH-1:0]   a_clamped, b_clamped, quotient;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               div_start, div_busy;

    always_comb begin
        a_clamped = (operand_a > MaxVal) ? MaxVal : operand_a;
        b_clamped = (operand_b > MaxVal) ? MaxVal : operand_b;
        sum       = {1'b0, a_q} + {1'b0, b_q};
        acc_next  = mplier_q[0] ? acc_q + mcand_q : acc_q;
        // Divider is launched on the same edge the operands are captured.
        div_start = (state_q == StIdle) && start && (op_t'(op) == OpDiv) && (b_clamped != '0);
    end

    div_restoring #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (a_clamped),
        .divisor  (b_clamped),
        .busy     (div_busy),
        .quotient (quotient)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            a_q      <= '0;
            b_q      <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StCalc;
                        op_q     <= op_t'(op);
                        a_q      <= a_clamped;
                        b_q      <= b_clamped;
                        mcand_q  <= {{WIDTH{1'b0}}, a_clamped};
                        mplier_q <= b_clamped;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StCalc: begin
                    unique case (op_q)
                        OpAdd: begin
                            state_q <= StDone;
                            if (sum > {1'b0, MaxVal}) begin
                                result_q <= MaxVal;
                                error_q  <= 1'b1;
                            end else begin
                                result_q <= sum[WIDTH-1:0];
                                error_q  <= 1'b0;
                            end
                        end
                        OpSub: begin
                            state_q <= StDone;
                            if (a_q < b_q) begin
                                result_q <= '0;
                                error_q  <= 1'b1;
                            end else begin
                                result_q <= a_q - b_q;
                                error_q  <= 1'b0;
                            end
                        end
                        OpMul: begin
                            // Shift-add: one multiplier bit per cycle.
                            acc_q    <= acc_next;
                            mcand_q  <= mcand_q << 1;
                            mplier_q <= mplier_q >> 1;
                            cnt_q    <= cnt_q + 1'b1;
                            if (cnt_q == CntW'(WIDTH - 1)) begin
                                state_q <= StDone;
                                if (acc_next > {{WIDTH{1'b0}}, MaxVal}) begin
                                    result_q <= MaxVal;
                                    error_q  <= 1'b1;
                                end else begin
                                    result_q <= acc_next[WIDTH-1:0];
                                    error_q  <= 1'b0;
                                end
                            end
                        end
                        OpDiv: begin
                            if (b_q == '0) begin
                                state_q  <= StDone;
                                result_q <= '0;
                                error_q  <= 1'b1;
                            end else if (!div_busy) begin
                                // Quotient of clamped operands never exceeds MaxVal.
                                state_q  <= StDone;
                                result_q <= quotient;
                                error_q  <= 1'b0;
                            end
                        end
                        default: state_q <= StDone;
                    endcase
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result = result_q;
    assign error  = error_q;
    assign busy   = (state_q == StCalc);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_calc_alu.sv
module tb_calc_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [13:0] operand_a;
    logic [13:0] operand_b;
    logic [13:0] result;
    logic        busy;
    logic        done;
    logic        error;

    calc_alu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        int res;
        int err;
        int edge_n;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   edge_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done with result=%0d at edge %0d, required none",
                         result, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", int'(result), e.res);
                chk("error", int'(error), e.err);
                chk("done_edge", edge_cnt, e.edge_n);
            end
        end
    end

    // lat: cycles from the capturing edge to the done cycle (2 or 15).
    task automatic issue(input int o, input int a, input int b, input int res, input int err,
                         input int lat);
        exp_t e;
        @(negedge clk);
        op        = 2'(o);
        operand_a = 14'(a);
        operand_b = 14'(b);
        start     = 1'b1;
        e.res     = res;
        e.err     = err;
        e.edge_n  = edge_cnt + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   base;
        total     = 0;
        bad       = 0;
        edge_cnt  = 0;
        reset     = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        operand_a = '0;
        operand_b = '0;

        repeat (3) @(negedge clk);
        chk("reset_result", int'(result), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_error", int'(error), 0);

        // ADD 1234+4321 issued on the first edge after reset release.
        reset     = 1'b1;
        op        = 2'd0;
        operand_a = 14'd1234;
        operand_b = 14'd4321;
        start     = 1'b1;
        e.res     = 5555;
        e.err     = 0;
        e.edge_n  = edge_cnt + 2;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("add_busy_n1", int'(busy), 1);
        chk("add_done_n1", int'(done), 0);
        @(negedge clk);
        chk("add_busy_n2", int'(busy), 0);
        drain();

        issue(0, 9000, 1000, 9999, 1, 2);
        drain();
        issue(1, 12, 34, 0, 1, 2);
        drain();
        issue(1, 34, 12, 22, 0, 2);
        drain();
        issue(2, 99, 100, 9900, 0, 15);
        drain();
        issue(2, 99, 102, 9999, 1, 15);
        drain();
        issue(3, 9999, 7, 1428, 0, 15);
        drain();
        issue(3, 5, 0, 0, 1, 2);
        drain();
        issue(3, 16383, 1, 9999, 0, 15);
        drain();

        // start held high through a MUL: second capture only once back in IDLE.
        @(negedge clk);
        op        = 2'd2;
        operand_a = 14'd7;
        operand_b = 14'd8;
        start     = 1'b1;
        base      = edge_cnt;
        e.res     = 56;
        e.err     = 0;
        e.edge_n  = base + 15;
        sb.push_back(e);
        e.edge_n  = base + 31;
        sb.push_back(e);
        while (edge_cnt < base + 17) @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in the middle of a MUL aborts it without a done pulse.
        @(negedge clk);
        op        = 2'd2;
        operand_a = 14'd50;
        operand_b = 14'd50;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_error", int'(error), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_result_held", int'(result), 0);

        issue(0, 1, 1, 2, 0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
